sync_fifo: RTL and testbench
============================

Name: sync_fifo

Overview:
Single-clock, parametrised FIFO. It is the same-domain successor to the dual-clock FIFO and is used where producer and consumer share one clock.
- Adds arbitrary (non-power-of-two) depth, a first-word-fall-through (FWFT) mode, an occupancy level output, programmable almost-full/almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags.

Parameters:
BITS, 32, width of each entry
SIZE, 16, number of entries; any integer >= 2
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
AFULL_THRESH, SIZE-2, wr_almost_full asserted when level >= this; range 1..SIZE
AEMPTY_THRESH, 2, rd_almost_empty asserted when level <= this; range 0..SIZE-1

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
clr  in  1  synchronous flush, active-high
wr_en  in  1  write request
wr_data  in  BITS  write data
wr_full  out  1  no space; writes are dropped
wr_almost_full  out  1  level >= AFULL_THRESH
rd_en  in  1  read request (standard) / pop (FWFT)
rd_data  out  BITS  read data
rd_valid  out  1  rd_data qualifier
rd_empty  out  1  nothing readable
rd_almost_empty  out  1  level <= AEMPTY_THRESH
level  out  CNT_W  occupancy, CNT_W = $clog2(SIZE+1)
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
Interface decision: one clock, clk; reset is asynchronous and active-high, rst.

Reset and flush:
- rst (async assert) and clr (sync, takes priority over wr_en/rd_en in the same cycle) both force:
  - wr_ptr = rd_ptr = 0, level = 0
  - wr_full = 0, wr_almost_full = (AFULL_THRESH == 0 ? 1 : 0), effectively 0 given the legal range
  - rd_empty = 1, rd_almost_empty = 1
  - rd_valid = 0, rd_data = 0
  - overflow = underflow = 0
- Storage array is not reset.

Accept rules:
- wr_acc = wr_en && !wr_full.
- rd_acc = rd_en && !rd_empty.
- Decided against fall-through-on-full: a write while full is dropped even if a read is accepted in the same cycle.

Pointers:
- Range 0..SIZE-1.
- Increment on accept; at SIZE-1 the pointer wraps to 0. No power-of-two assumption.

Level and flags:
- level_next = level + wr_acc - rd_acc, with no over- or underflow possible.
- All flags are registered, computed from level_next:
  - wr_full = (level_next == SIZE)
  - wr_almost_full = (level_next >= AFULL_THRESH)
  - rd_almost_empty = (level_next <= AEMPTY_THRESH)
- Write-to-not-empty latency is 1 cycle. Full-to-not-full after a read is 1 cycle.

Standard mode (FWFT = 0):
- rd_empty = (level == 0).
- On rd_acc, rd_data is loaded from mem[rd_ptr] at the next edge, and rd_valid pulses high for that one cycle.
- rd_data holds its value otherwise.

FWFT mode (FWFT = 1):
- Adds a one-entry output register. level counts that register too, so the maximum total is still SIZE, the array holding SIZE-1 when the output register is full; full is driven from level.
- rd_valid = (output register occupied); rd_empty = !rd_valid.
- A write into an empty FIFO is visible on rd_data with rd_valid = 1 in the cycle after wr_acc.
- rd_en with rd_valid pops the word. Refill comes from the array in the same edge if the array is non-empty; otherwise rd_valid drops.
- Simultaneous write and pop with only one word present: the new word goes straight to the output register, and rd_valid stays 1.

Simultaneous events:
- wr_acc and rd_acc together leave level unchanged and advance both pointers.
- Empty with wr_en and rd_en: only the write is accepted, and underflow is set.

Error flags:
- overflow is set on (wr_en && wr_full).
- underflow is set on (rd_en && rd_empty).
- Both are sticky until rst or clr.

Elaboration:
- SIZE < 2, or either threshold outside its range, is a fatal elaboration error.

Decomposition:
Package fifo_pkg holds:
- function clog2_cnt(size), giving CNT_W
- typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e
- parameter legality check macros, shared with the dual-clock FIFO

One sub-module, fifo_mem:
- SIZE x BITS simple dual-port array
- Synchronous write, combinational read by index
- Lets the array be swapped for a RAM macro later

The FWFT output register lives in sync_fifo.

Test Plan:
1. SIZE=4, BITS=8, FWFT=0: reset, then write 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> level goes 1,2,3,4; wr_full=1 after the 4th; wr_almost_full=1 at level 2; rd_empty=0 one cycle after the first write.
2. Same configuration, full, then wr_en with 0x55 -> dropped and overflow=1; 4 reads -> rd_data 0x11..0x44 each with a one-cycle rd_valid pulse; then rd_empty=1 and rd_almost_empty=1.
3. SIZE=5 (non-power-of-two): 12 write/read pairs with data equal to the index -> ordering preserved across wrap; level stays 1 at steady state.
4. FWFT=1, SIZE=4: write 0xA5 into an empty FIFO -> rd_valid=1 and rd_data=0xA5 the next cycle, with no rd_en; pop with a same-cycle write of 0x5A -> rd_valid stays 1 and rd_data=0x5A.
5. Empty FIFO with rd_en and wr_en=0x77 in the same cycle -> underflow=1, level=1, the word is later read as 0x77; clr asserted mid-stream with wr_en high -> level=0, flags reset, sticky flags cleared, the write is ignored.
6. rst asserted asynchronously between clock edges while level=3 -> all outputs take reset values immediately; on release, the FIFO behaves as empty.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO types, helpers and parameter legality checks (also used by the dual-clock FIFO).
`ifndef FIFO_PKG_SV
`define FIFO_PKG_SV

// Elaboration-time guards; expand inside a module body at generate scope.
`define FIFO_CHECK_MIN(lbl, val, lo) \
    if ((val) < (lo)) begin : lbl \
        $fatal(1, "fifo parameter below its minimum"); \
    end

`define FIFO_CHECK_RANGE(lbl, val, lo, hi) \
    if (((val) < (lo)) || ((val) > (hi))) begin : lbl \
        $fatal(1, "fifo parameter outside its legal range"); \
    end

package fifo_pkg;

    typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;

    // Width needed to hold an occupancy of 0..size inclusive.
    function automatic int clog2_cnt(input int size);
        return $clog2(size + 1);
    endfunction

endpackage

`endif

// File: rtl/fifo_mem.sv
// SIZE x BITS simple dual-port storage: synchronous write, combinational read by index.
// Kept separate so the array can later be replaced by a RAM macro.
module fifo_mem #(
    parameter int BITS = 32,
    parameter int SIZE = 16,
    localparam int AW  = $clog2(SIZE)
) (
    input  logic            i_clk,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [BITS-1:0] i_wdata,
    input  logic [AW-1:0]   i_raddr,
    output logic [BITS-1:0] o_rdata
);

    logic [BITS-1:0] r_mem [SIZE];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with arbitrary depth, optional first-word-fall-through output register,
// registered level/threshold flags, synchronous flush and sticky overflow/underflow flags.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int BITS          = 32,
    parameter int SIZE          = 16,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = SIZE - 2,
    parameter int AEMPTY_THRESH = 2,
    localparam int CNT_W        = clog2_cnt(SIZE)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_wr_en,
    input  logic [BITS-1:0]  i_wr_data,
    output logic             o_wr_full,
    output logic             o_wr_almost_full,
    input  logic             i_rd_en,
    output logic [BITS-1:0]  o_rd_data,
    output logic             o_rd_valid,
    output logic             o_rd_empty,
    output logic             o_rd_almost_empty,
    output logic [CNT_W-1:0] o_level,
    output logic             o_overflow,
    output logic             o_underflow
);

    localparam int               PTR_W    = $clog2(SIZE);
    localparam fifo_mode_e       MODE     = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
    localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(SIZE);
    localparam logic [CNT_W-1:0] AF_LVL   = CNT_W'(AFULL_THRESH);
    localparam logic [CNT_W-1:0] AE_LVL   = CNT_W'(AEMPTY_THRESH);

    `FIFO_CHECK_MIN(g_chk_size, SIZE, 2)
    `FIFO_CHECK_RANGE(g_chk_afull, AFULL_THRESH, 1, SIZE)
    `FIFO_CHECK_RANGE(g_chk_aempty, AEMPTY_THRESH, 0, SIZE - 1)
    `FIFO_CHECK_RANGE(g_chk_fwft, FWFT, 0, 1)

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_level;
    logic             r_full;
    logic             r_afull;
    logic             r_empty;
    logic             r_aempty;
    logic             r_rd_vld;
    logic [BITS-1:0]  r_rd_dat;
    logic             r_ovf;
    logic             r_udf;

    logic             w_wr_acc;
    logic             w_rd_acc;
    logic             w_mem_empty;
    logic             w_bypass;
    logic             w_mem_we;
    logic             w_mem_re;
    logic             w_load;
    logic             w_vld_nxt;
    logic [BITS-1:0]  w_load_dat;
    logic [BITS-1:0]  w_mem_rdata;
    logic [CNT_W-1:0] w_level_nxt;

    function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SIZE - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        w_wr_acc    = i_wr_en && !r_full;
        w_rd_acc    = i_rd_en && !r_empty;
        w_level_nxt = r_level + CNT_W'(w_wr_acc) - CNT_W'(w_rd_acc);
        // In FWFT the array never holds more than SIZE-1 words, so equal pointers mean empty.
        w_mem_empty = (r_wr_ptr == r_rd_ptr);
        w_bypass    = 1'b0;
        w_mem_re    = w_rd_acc;
        w_load      = w_rd_acc;
        w_load_dat  = w_mem_rdata;
        w_vld_nxt   = w_rd_acc;
        if (MODE == FIFO_FWFT) begin
            // Write goes straight to the output register when nothing else would fill it.
            w_bypass   = w_wr_acc && (r_empty || (w_rd_acc && w_mem_empty));
            w_mem_re   = w_rd_acc && !w_mem_empty;
            w_load     = w_bypass || w_mem_re;
            w_load_dat = w_mem_re ? w_mem_rdata : i_wr_data;
            w_vld_nxt  = (w_level_nxt != '0);
        end
        w_mem_we = w_wr_acc && !w_bypass;
    end

    fifo_mem #(
        .BITS (BITS),
        .SIZE (SIZE)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (w_mem_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (i_wr_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_afull  <= (AF_LVL == '0);
            r_empty  <= 1'b1;
            r_aempty <= 1'b1;
            r_rd_vld <= 1'b0;
            r_rd_dat <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_afull  <= (AF_LVL == '0);
            r_empty  <= 1'b1;
            r_aempty <= 1'b1;
            r_rd_vld <= 1'b0;
            r_rd_dat <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_mem_we) begin
                r_wr_ptr <= f_inc(r_wr_ptr);
            end
            if (w_mem_re) begin
                r_rd_ptr <= f_inc(r_rd_ptr);
            end
            r_level  <= w_level_nxt;
            r_full   <= (w_level_nxt == FULL_LVL);
            r_afull  <= (w_level_nxt >= AF_LVL);
            r_empty  <= (w_level_nxt == '0);
            r_aempty <= (w_level_nxt <= AE_LVL);
            r_rd_vld <= w_vld_nxt;
            if (w_load) begin
                r_rd_dat <= w_load_dat;
            end
            if (i_wr_en && r_full) begin
                r_ovf <= 1'b1;
            end
            if (i_rd_en && r_empty) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign o_wr_full         = r_full;
    assign o_wr_almost_full  = r_afull;
    assign o_rd_data         = r_rd_dat;
    assign o_rd_valid        = r_rd_vld;
    assign o_rd_empty        = r_empty;
    assign o_rd_almost_empty = r_aempty;
    assign o_level           = r_level;
    assign o_overflow        = r_ovf;
    assign o_underflow       = r_udf;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench: A = SIZE 4 standard, B = SIZE 5 standard, C = SIZE 4 FWFT (all 8-bit).
module tb_sync_fifo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       a_clr = 0, a_wr_en = 0, a_rd_en = 0;
    logic [7:0] a_wr_dat = 0, a_rd_dat;
    logic       a_full, a_afull, a_rd_vld, a_empty, a_aempty, a_ovf, a_udf;
    logic [2:0] a_level;

    logic       b_clr = 0, b_wr_en = 0, b_rd_en = 0;
    logic [7:0] b_wr_dat = 0, b_rd_dat;
    logic       b_full, b_afull, b_rd_vld, b_empty, b_aempty, b_ovf, b_udf;
    logic [2:0] b_level;

    logic       c_clr = 0, c_wr_en = 0, c_rd_en = 0;
    logic [7:0] c_wr_dat = 0, c_rd_dat;
    logic       c_full, c_afull, c_rd_vld, c_empty, c_aempty, c_ovf, c_udf;
    logic [2:0] c_level;

    int total = 0;
    int bad   = 0;

    sync_fifo #(.BITS(8), .SIZE(4), .FWFT(0)) u_a (
        .i_clk(clk), .i_rst(rst), .i_clr(a_clr),
        .i_wr_en(a_wr_en), .i_wr_data(a_wr_dat), .o_wr_full(a_full), .o_wr_almost_full(a_afull),
        .i_rd_en(a_rd_en), .o_rd_data(a_rd_dat), .o_rd_valid(a_rd_vld), .o_rd_empty(a_empty),
        .o_rd_almost_empty(a_aempty), .o_level(a_level), .o_overflow(a_ovf), .o_underflow(a_udf)
    );

    sync_fifo #(.BITS(8), .SIZE(5), .FWFT(0)) u_b (
        .i_clk(clk), .i_rst(rst), .i_clr(b_clr),
        .i_wr_en(b_wr_en), .i_wr_data(b_wr_dat), .o_wr_full(b_full), .o_wr_almost_full(b_afull),
        .i_rd_en(b_rd_en), .o_rd_data(b_rd_dat), .o_rd_valid(b_rd_vld), .o_rd_empty(b_empty),
        .o_rd_almost_empty(b_aempty), .o_level(b_level), .o_overflow(b_ovf), .o_underflow(b_udf)
    );

    sync_fifo #(.BITS(8), .SIZE(4), .FWFT(1)) u_c (
        .i_clk(clk), .i_rst(rst), .i_clr(c_clr),
        .i_wr_en(c_wr_en), .i_wr_data(c_wr_dat), .o_wr_full(c_full), .o_wr_almost_full(c_afull),
        .i_rd_en(c_rd_en), .o_rd_data(c_rd_dat), .o_rd_valid(c_rd_vld), .o_rd_empty(c_empty),
        .o_rd_almost_empty(c_aempty), .o_level(c_level), .o_overflow(c_ovf), .o_underflow(c_udf)
    );

    // Inputs change at the falling edge; outputs are observed at the following falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        tick();
        total++; if (a_level !== 3'd0) begin bad++; $display("FAIL rst_level got=%0d want=0", a_level); end
        total++; if (a_full !== 1'b0) begin bad++; $display("FAIL rst_full got=%b want=0", a_full); end
        total++; if (a_afull !== 1'b0) begin bad++; $display("FAIL rst_afull got=%b want=0", a_afull); end
        total++; if (a_empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b want=1", a_empty); end
        total++; if (a_aempty !== 1'b1) begin bad++; $display("FAIL rst_aempty got=%b want=1", a_aempty); end
        total++; if (a_rd_vld !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", a_rd_vld); end
        total++; if (a_rd_dat !== 8'h00) begin bad++; $display("FAIL rst_data got=%h want=00", a_rd_dat); end
        total++; if ({a_ovf, a_udf} !== 2'b00) begin bad++; $display("FAIL rst_errflags got=%b want=00", {a_ovf, a_udf}); end
        total++; if ({c_rd_vld, c_empty} !== 2'b01) begin bad++; $display("FAIL rst_fwft got=%b want=01", {c_rd_vld, c_empty}); end
        total++; if (b_level !== 3'd0) begin bad++; $display("FAIL rst_b_level got=%0d want=0", b_level); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fill();
        logic [7:0] want_dat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic       want_af  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic       want_fl  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic       want_ae  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        a_wr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_wr_dat = want_dat[i];
            tick();
            total++; if (a_level !== 3'(i + 1)) begin bad++; $display("FAIL fill_level[%0d] got=%0d want=%0d", i, a_level, i + 1); end
            total++; if (a_afull !== want_af[i]) begin bad++; $display("FAIL fill_afull[%0d] got=%b want=%b", i, a_afull, want_af[i]); end
            total++; if (a_full !== want_fl[i]) begin bad++; $display("FAIL fill_full[%0d] got=%b want=%b", i, a_full, want_fl[i]); end
            total++; if (a_aempty !== want_ae[i]) begin bad++; $display("FAIL fill_aempty[%0d] got=%b want=%b", i, a_aempty, want_ae[i]); end
            total++; if (a_empty !== 1'b0) begin bad++; $display("FAIL fill_empty[%0d] got=%b want=0", i, a_empty); end
        end
        a_wr_en = 1'b0;
    endtask

    task automatic test_overflow_drain();
        logic [7:0] want_dat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        a_wr_en = 1'b1; a_wr_dat = 8'h55;
        tick();
        a_wr_en = 1'b0;
        total++; if (a_ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", a_ovf); end
        total++; if (a_level !== 3'd4) begin bad++; $display("FAIL ovf_level got=%0d want=4", a_level); end
        a_rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (a_rd_vld !== 1'b1) begin bad++; $display("FAIL drain_valid[%0d] got=%b want=1", i, a_rd_vld); end
            total++; if (a_rd_dat !== want_dat[i]) begin bad++; $display("FAIL drain_data[%0d] got=%h want=%h", i, a_rd_dat, want_dat[i]); end
            total++; if (a_level !== 3'(3 - i)) begin bad++; $display("FAIL drain_level[%0d] got=%0d want=%0d", i, a_level, 3 - i); end
            total++; if (a_full !== 1'b0) begin bad++; $display("FAIL drain_full[%0d] got=%b want=0", i, a_full); end
        end
        a_rd_en = 1'b0;
        total++; if ({a_empty, a_aempty} !== 2'b11) begin bad++; $display("FAIL drain_empty got=%b want=11", {a_empty, a_aempty}); end
        tick();
        total++; if (a_rd_vld !== 1'b0) begin bad++; $display("FAIL drain_pulse got=%b want=0", a_rd_vld); end
        total++; if (a_rd_dat !== 8'h44) begin bad++; $display("FAIL drain_hold got=%h want=44", a_rd_dat); end
        total++; if ({a_ovf, a_udf} !== 2'b10) begin bad++; $display("FAIL drain_sticky got=%b want=10", {a_ovf, a_udf}); end
    endtask

    task automatic test_wrap();
        b_wr_en = 1'b1; b_wr_dat = 8'd0;
        tick();
        b_rd_en = 1'b1;
        for (int i = 1; i < 12; i++) begin
            b_wr_dat = 8'(i);
            tick();
            total++; if (b_rd_dat !== 8'(i - 1)) begin bad++; $display("FAIL wrap_data[%0d] got=%0d want=%0d", i, b_rd_dat, i - 1); end
            total++; if (b_level !== 3'd1) begin bad++; $display("FAIL wrap_level[%0d] got=%0d want=1", i, b_level); end
            total++; if (b_rd_vld !== 1'b1) begin bad++; $display("FAIL wrap_valid[%0d] got=%b want=1", i, b_rd_vld); end
        end
        b_wr_en = 1'b0;
        tick();
        b_rd_en = 1'b0;
        total++; if (b_rd_dat !== 8'd11) begin bad++; $display("FAIL wrap_last got=%0d want=11", b_rd_dat); end
        total++; if ({b_level, b_empty} !== 4'b0001) begin bad++; $display("FAIL wrap_end got=%b want=0001", {b_level, b_empty}); end
    endtask

    task automatic test_fwft();
        c_wr_en = 1'b1; c_wr_dat = 8'hA5;
        tick();
        c_wr_en = 1'b0;
        total++; if ({c_rd_vld, c_empty} !== 2'b10) begin bad++; $display("FAIL fwft_vis got=%b want=10", {c_rd_vld, c_empty}); end
        total++; if (c_rd_dat !== 8'hA5) begin bad++; $display("FAIL fwft_data got=%h want=a5", c_rd_dat); end
        c_wr_en = 1'b1; c_wr_dat = 8'h5A; c_rd_en = 1'b1;
        tick();
        c_rd_en = 1'b0;
        total++; if (c_rd_vld !== 1'b1) begin bad++; $display("FAIL fwft_bypass_vld got=%b want=1", c_rd_vld); end
        total++; if (c_rd_dat !== 8'h5A) begin bad++; $display("FAIL fwft_bypass_data got=%h want=5a", c_rd_dat); end
        total++; if (c_level !== 3'd1) begin bad++; $display("FAIL fwft_bypass_level got=%0d want=1", c_level); end
        c_wr_dat = 8'hB1; tick();
        c_wr_dat = 8'hB2; tick();
        c_wr_en = 1'b0;
        total++; if ({c_level, c_rd_dat} !== {3'd3, 8'h5A}) begin bad++; $display("FAIL fwft_hold got=%0d/%h want=3/5a", c_level, c_rd_dat); end
        c_rd_en = 1'b1;
        tick();
        total++; if ({c_level, c_rd_dat} !== {3'd2, 8'hB1}) begin bad++; $display("FAIL fwft_pop1 got=%0d/%h want=2/b1", c_level, c_rd_dat); end
        tick();
        total++; if ({c_level, c_rd_dat} !== {3'd1, 8'hB2}) begin bad++; $display("FAIL fwft_pop2 got=%0d/%h want=1/b2", c_level, c_rd_dat); end
        tick();
        c_rd_en = 1'b0;
        total++; if ({c_level, c_rd_vld, c_empty} !== 5'b00001) begin bad++; $display("FAIL fwft_drop got=%b want=00001", {c_level, c_rd_vld, c_empty}); end
        c_wr_en = 1'b1;
        c_wr_dat = 8'hE1; tick();
        c_wr_dat = 8'hE2; tick();
        c_wr_dat = 8'hE3; tick();
        c_wr_dat = 8'hE4; tick();
        total++; if ({c_level, c_full, c_afull} !== 5'b10011) begin bad++; $display("FAIL fwft_full got=%b want=10011", {c_level, c_full, c_afull}); end
        total++; if (c_rd_dat !== 8'hE1) begin bad++; $display("FAIL fwft_full_head got=%h want=e1", c_rd_dat); end
        c_wr_dat = 8'hF0; tick();
        c_wr_en = 1'b0;
        total++; if ({c_ovf, c_level} !== 4'b1100) begin bad++; $display("FAIL fwft_ovf got=%b want=1100", {c_ovf, c_level}); end
        c_rd_en = 1'b1;
        tick();
        c_rd_en = 1'b0;
        total++; if ({c_level, c_full, c_rd_dat} !== {3'd3, 1'b0, 8'hE2}) begin bad++; $display("FAIL fwft_wrap_pop got=%0d/%b/%h want=3/0/e2", c_level, c_full, c_rd_dat); end
    endtask

    task automatic test_underflow_clr();
        a_wr_en = 1'b1; a_wr_dat = 8'h77; a_rd_en = 1'b1;
        tick();
        a_wr_en = 1'b0;
        total++; if (a_udf !== 1'b1) begin bad++; $display("FAIL udf_set got=%b want=1", a_udf); end
        total++; if ({a_level, a_rd_vld} !== 4'b0010) begin bad++; $display("FAIL udf_level got=%b want=0010", {a_level, a_rd_vld}); end
        tick();
        a_rd_en = 1'b0;
        total++; if ({a_rd_vld, a_rd_dat} !== {1'b1, 8'h77}) begin bad++; $display("FAIL udf_read got=%b/%h want=1/77", a_rd_vld, a_rd_dat); end
        a_wr_en = 1'b1;
        a_wr_dat = 8'h01; tick();
        a_wr_dat = 8'h02; tick();
        a_clr = 1'b1; a_wr_dat = 8'h03;
        tick();
        a_clr = 1'b0; a_wr_en = 1'b0;
        total++; if (a_level !== 3'd0) begin bad++; $display("FAIL clr_level got=%0d want=0", a_level); end
        total++; if ({a_empty, a_aempty, a_full, a_afull} !== 4'b1100) begin bad++; $display("FAIL clr_flags got=%b want=1100", {a_empty, a_aempty, a_full, a_afull}); end
        total++; if ({a_ovf, a_udf} !== 2'b00) begin bad++; $display("FAIL clr_sticky got=%b want=00", {a_ovf, a_udf}); end
        total++; if ({a_rd_vld, a_rd_dat} !== 9'h000) begin bad++; $display("FAIL clr_out got=%b/%h want=0/00", a_rd_vld, a_rd_dat); end
        a_rd_en = 1'b1;
        tick();
        a_rd_en = 1'b0;
        total++; if ({a_rd_vld, a_udf} !== 2'b01) begin bad++; $display("FAIL clr_nowrite got=%b want=01", {a_rd_vld, a_udf}); end
    endtask

    task automatic test_async_rst();
        a_wr_en = 1'b1;
        a_wr_dat = 8'hC1; tick();
        a_wr_dat = 8'hC2; tick();
        a_wr_dat = 8'hC3; tick();
        a_wr_dat = 8'hC4; tick();
        a_wr_en = 1'b0; a_rd_en = 1'b1;
        tick();
        a_rd_en = 1'b0;
        total++; if ({a_level, a_rd_dat} !== {3'd3, 8'hC1}) begin bad++; $display("FAIL arst_pre got=%0d/%h want=3/c1", a_level, a_rd_dat); end
        #2 rst = 1'b1;
        #1;
        total++; if (a_level !== 3'd0) begin bad++; $display("FAIL arst_level got=%0d want=0", a_level); end
        total++; if ({a_rd_vld, a_rd_dat} !== 9'h000) begin bad++; $display("FAIL arst_out got=%b/%h want=0/00", a_rd_vld, a_rd_dat); end
        total++; if ({a_empty, a_aempty, a_full, a_afull, a_udf} !== 5'b11000) begin bad++; $display("FAIL arst_flags got=%b want=11000", {a_empty, a_aempty, a_full, a_afull, a_udf}); end
        #1 rst = 1'b0;
        tick();
        a_wr_en = 1'b1; a_wr_dat = 8'hD1;
        tick();
        a_wr_en = 1'b0;
        total++; if (a_level !== 3'd1) begin bad++; $display("FAIL arst_after_wr got=%0d want=1", a_level); end
        a_rd_en = 1'b1;
        tick();
        a_rd_en = 1'b0;
        total++; if ({a_rd_vld, a_rd_dat, a_level} !== {1'b1, 8'hD1, 3'd0}) begin bad++; $display("FAIL arst_after_rd got=%b/%h/%0d want=1/d1/0", a_rd_vld, a_rd_dat, a_level); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow_drain();
        test_wrap();
        test_fwft();
        test_underflow_clr();
        test_async_rst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
